// File: rtl/multibyte_add_controller.sv
// Purpose : NBYTES-wide add (optionally subtract) by stepping one 8-bit ripple adder LSB-first.
// Latency : start accepted at edge k -> done pulses in the cycle after edge k+NBYTES.
// Backpr. : none; start is ignored while busy, accepted in IDLE or in the DONE cycle.
//
// Ports (controller):
//   clk, rst_n          clock, asynchronous active-low reset
//   start, a, b, cy_in  request and operands, captured on an accepted start
//   op                  (MULTIBYTE_ADD_SUB_EN only) 1 = a - b, 0 = a + b + cy_in
//   busy, done          busy for NBYTES cycles, one-cycle done pulse
//   sum, cy_out         result and top carry, held until the next accepted start
// Optional feature macro: MULTIBYTE_ADD_SUB_EN (adds op port and subtract path).

module ripple_carry_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cy_in,
  output logic [7:0] sum,
  output logic       cy_out
);
  logic [8:0] c;

  always_comb begin
    c      = '0;
    sum    = '0;
    c[0]   = cy_in;
    for (int i = 0; i < 8; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cy_out = c[8];
  end
endmodule

module multibyte_add_controller #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  input  logic                cy_in,
`ifdef MULTIBYTE_ADD_SUB_EN
  input  logic                op,
`endif
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] sum,
  output logic                cy_out
);
  localparam int IDXW = $clog2(NBYTES);
  localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                      state_q, state_d;
  logic                        accept;
  logic                        last;

  logic [NBYTES-1:0][7:0]      a_q, b_q, sum_q;
  logic [IDXW-1:0]             idx_q;
  logic                        carry_q;
  logic                        cy_out_q;

  logic [7:0]                  add_a, add_b, add_sum;
  logic                        add_cy;
  logic                        start_carry;

`ifdef MULTIBYTE_ADD_SUB_EN
  logic                        op_q;
  // Subtract is a + ~b + 1; the forced carry-in supplies the +1.
  assign add_b       = op_q ? ~b_q[idx_q] : b_q[idx_q];
  assign start_carry = op ? 1'b1 : cy_in;
`else
  assign add_b       = b_q[idx_q];
  assign start_carry = cy_in;
`endif
  assign add_a = a_q[idx_q];

  ripple_carry_adder u_adder (
    .a      (add_a),
    .b      (add_b),
    .cy_in  (carry_q),
    .sum    (add_sum),
    .cy_out (add_cy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = (idx_q == LAST);
    case (state_q)
      IDLE: if (start) begin
        accept  = 1'b1;
        state_d = RUN;
      end
      RUN:  if (last) state_d = DONE;
      DONE: begin
        // A start in the done cycle chains straight into the next operation.
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      cy_out_q <= 1'b0;
`ifdef MULTIBYTE_ADD_SUB_EN
      op_q     <= 1'b0;
`endif
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      idx_q   <= '0;
      carry_q <= start_carry;
`ifdef MULTIBYTE_ADD_SUB_EN
      op_q    <= op;
`endif
    end else if (state_q == RUN) begin
      sum_q[idx_q] <= add_sum;
      carry_q      <= add_cy;
      if (last) begin
        idx_q    <= '0;
        cy_out_q <= add_cy;
      end else begin
        idx_q    <= idx_q + IDXW'(1);
      end
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign sum    = sum_q;
  assign cy_out = cy_out_q;
endmodule

// File: tb/tb_multibyte_add_controller.sv
// Purpose : directed self-checking bench for multibyte_add_controller with NBYTES=4.
// Latency : expects done in the 5th cycle after the accepting edge, busy for 4 cycles.
// Backpr. : exercises ignored start while busy and back-to-back start in the done cycle.

module tb_multibyte_add_controller;
  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cy_in;
`ifdef MULTIBYTE_ADD_SUB_EN
  logic         op;
`endif
  logic         busy, done, cy_out;
  logic [W-1:0] sum;

  int tests_run = 0;
  int tests_failed = 0;

  multibyte_add_controller #(.NBYTES(NBYTES)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .cy_in  (cy_in),
`ifdef MULTIBYTE_ADD_SUB_EN
    .op     (op),
`endif
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .cy_out (cy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives a one-cycle start; returns just after the accepting edge.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    a = ta; b = tb; cy_in = tc; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts cycles (sampled on negedge) until done; cyc=0 on timeout.
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = 0; busy_cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin cyc = i; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cy_in = 1'b0;
`ifdef MULTIBYTE_ADD_SUB_EN
    op = 1'b0;
`endif
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, done, cy_out} !== 3'b000 || sum !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b done=%b cy_out=%b sum=%h, want all zero", busy, done, cy_out, sum);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_plain_add;
    int cyc, bc;
    start_op(32'h00000001, 32'h00000045, 1'b1);
    wait_done(cyc, bc);
    tests_run++;
    if (cyc !== 5) begin tests_failed++; $display("FAIL plain_latency: done at cycle %0d, want 5", cyc); end
    tests_run++;
    if (bc !== 4) begin tests_failed++; $display("FAIL plain_busy: busy %0d cycles, want 4", bc); end
    tests_run++;
    if (sum !== 32'h00000047 || cy_out !== 1'b0) begin
      tests_failed++; $display("FAIL plain_result: sum=%h cy=%b, want 00000047/0", sum, cy_out);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || sum !== 32'h00000047) begin
      tests_failed++; $display("FAIL plain_idle: done=%b busy=%b sum=%h, want 0/0/00000047", done, busy, sum);
    end
  endtask

  task automatic test_carry_ripple;
    int cyc;
    int bad_carry;
    cyc = 0; bad_carry = 0;
    start_op(32'hFFFFFFFF, 32'h00000001, 1'b0);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      // After each processed byte the chained carry must be 1.
      if (i >= 2 && dut.carry_q !== 1'b1) bad_carry++;
      if (done) begin cyc = i; break; end
    end
    tests_run++;
    if (cyc !== 5) begin tests_failed++; $display("FAIL ripple_latency: done at cycle %0d, want 5", cyc); end
    tests_run++;
    if (bad_carry !== 0) begin tests_failed++; $display("FAIL ripple_carry_chain: %0d cycles with carry 0, want 0", bad_carry); end
    tests_run++;
    if (sum !== 32'h00000000 || cy_out !== 1'b1) begin
      tests_failed++; $display("FAIL ripple_result: sum=%h cy=%b, want 00000000/1", sum, cy_out);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int cyc, bc, dones;
    cyc = 0; dones = 0;
    start_op(32'h00000010, 32'h00000020, 1'b0);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 2) begin a = 32'h11111111; b = 32'h22222222; cy_in = 1'b1; start = 1'b1; end
      else if (i == 3) start = 1'b0;
      if (done) begin dones++; cyc = i; break; end
    end
    tests_run++;
    if (cyc !== 5 || dones !== 1) begin
      tests_failed++; $display("FAIL ignored_start_timing: done at %0d count %0d, want 5/1", cyc, dones);
    end
    tests_run++;
    if (sum !== 32'h00000030 || cy_out !== 1'b0) begin
      tests_failed++; $display("FAIL ignored_start_result: sum=%h cy=%b, want 00000030/0", sum, cy_out);
    end
    // Start issued in the done cycle itself.
    start_op(32'h000000FF, 32'h00000001, 1'b0);
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_accept: busy=%b, want 1", busy); end
    wait_done(cyc, bc);
    tests_run++;
    if (cyc !== 5 || bc !== 4) begin
      tests_failed++; $display("FAIL b2b_latency: done at %0d busy %0d, want 5/4", cyc, bc);
    end
    tests_run++;
    if (sum !== 32'h00000100 || cy_out !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_result: sum=%h cy=%b, want 00000100/0", sum, cy_out);
    end
    dones = 0;
    repeat (6) begin @(negedge clk); if (done) dones++; end
    tests_run++;
    if (dones !== 0) begin tests_failed++; $display("FAIL b2b_extra_done: %0d extra pulses, want 0", dones); end
  endtask

  task automatic test_reset_mid_op;
    int cyc, bc, dones;
    start_op(32'h12345678, 32'h11111111, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, cy_out} !== 3'b000 || sum !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_op: busy=%b done=%b cy=%b sum=%h, want all zero", busy, done, cy_out, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (8) begin @(negedge clk); if (done || busy) dones++; end
    tests_run++;
    if (dones !== 0) begin tests_failed++; $display("FAIL reset_no_done: %0d active cycles, want 0", dones); end
    start_op(32'h12345678, 32'h11111111, 1'b0);
    wait_done(cyc, bc);
    tests_run++;
    if (cyc !== 5 || sum !== 32'h23456789 || cy_out !== 1'b0) begin
      tests_failed++; $display("FAIL reset_fresh_op: cyc=%0d sum=%h cy=%b, want 5/23456789/0", cyc, sum, cy_out);
    end
    @(negedge clk);
  endtask

`ifdef MULTIBYTE_ADD_SUB_EN
  task automatic test_subtract;
    int cyc, bc;
    op = 1'b1;
    start_op(32'h00000100, 32'h00000001, 1'b0);
    op = 1'b0;
    wait_done(cyc, bc);
    tests_run++;
    if (cyc !== 5 || sum !== 32'h000000FF || cy_out !== 1'b1) begin
      tests_failed++; $display("FAIL sub_no_borrow: cyc=%0d sum=%h cy=%b, want 5/000000FF/1", cyc, sum, cy_out);
    end
    @(negedge clk);
    op = 1'b1;
    start_op(32'h00000001, 32'h00000002, 1'b1);
    op = 1'b0;
    wait_done(cyc, bc);
    tests_run++;
    if (cyc !== 5 || sum !== 32'hFFFFFFFF || cy_out !== 1'b0) begin
      tests_failed++; $display("FAIL sub_borrow: cyc=%0d sum=%h cy=%b, want 5/FFFFFFFF/0", cyc, sum, cy_out);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_plain_add();
    test_carry_ripple();
    test_back_to_back();
    test_reset_mid_op();
`ifdef MULTIBYTE_ADD_SUB_EN
    test_subtract();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/multibyte_add_controller.md
Name: multibyte_add_controller

Overview:
- Sequencer that performs an NBYTES-wide addition by time-multiplexing one 8-bit ripple_carry_adder instance (ports a, b, cy_in, sum, cy_out), one byte per clock, LSB first.
- Chains each byte's carry-out into the next byte's carry-in through a register.
- Sits between a requester issuing start/operands and the shared 8-bit adder datapath. Exposes a busy/done handshake and a held result.

Parameters:
- NBYTES, 4, operand width in bytes (width W = 8*NBYTES); legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when not busy
- a  input  W  operand A, captured on accepted start
- b  input  W  operand B, captured on accepted start
- cy_in  input  1  carry into byte 0, captured on accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when sum/cy_out become valid
- sum  output  W  result, held until next accepted start or reset
- cy_out  output  1  carry out of top byte, held like sum

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, sum=0, cy_out=0; byte index=0; carry register=0; operand registers=0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge k -> latch a, b, cy_in into the carry register; idx=0; busy=1; state=RUN.
- RUN: adder inputs = byte idx of latched a and b, plus the carry register.
  - Each edge: write adder sum into sum[8*idx+7:8*idx]; carry register <= adder cy_out; idx++.
  - Edge at which idx==NBYTES-1: cy_out <= adder cy_out; state=DONE; busy=0; done=1.
- Latency: start accepted at edge k -> done high in the cycle after edge k+NBYTES; busy high for exactly NBYTES cycles.
- DONE: done=1 for this cycle only.
  - start=1 -> accepted as in IDLE (back-to-back, no bubble).
  - Otherwise -> IDLE.
- start while busy=1: ignored, no effect on operands or result.
- Operand changes while busy: no effect (captured copies used).
- sum bytes update progressively during RUN. Only the value present while done=1 or later is architecturally valid.
- sum upper bytes from the previous result persist until overwritten. A new accepted start does not clear sum.
- Arithmetic: result = (a + b + cy_in) mod 2^W; cy_out = bit W of the full sum.
- Reset asserted mid-operation: abort immediately to the reset values; no done pulse.

Optional Feature:
- Macro: MULTIBYTE_ADD_SUB_EN.
- Defined:
  - Extra input port op (1 bit), captured on accepted start.
  - op=1: adder B input = ~b byte; carry into byte 0 forced to 1 (cy_in ignored).
  - Result = a - b mod 2^W; cy_out=1 means no borrow (a >= b unsigned).
  - op=0: identical to plain add.
- Undefined: no op port; addition only; no extra logic.

Test Plan (NBYTES=4):
- Plain add: a=0x00000001, b=0x00000045, cy_in=1, start 1 cycle.
  - Expect busy high 4 cycles; done pulse exactly 4 cycles after start edge; sum=0x00000047, cy_out=0.
- Full carry ripple: a=0xFFFFFFFF, b=0x00000001, cy_in=0.
  - Expect sum=0x00000000, cy_out=1; intermediate carry register=1 at every byte.
- Ignored start and back-to-back:
  - Pulse start with a=0x11111111, b=0x22222222 during busy of op 0x10+0x20.
  - Expect first result 0x00000030; no extra done.
  - Then assert start in the done cycle with 0x000000FF+0x00000001 -> next done 4 cycles later, sum=0x00000100.
- Reset mid-op: start 0x12345678+0x11111111, drop rst_n after 2 cycles.
  - Expect busy=0, done=0, sum=0, cy_out=0 immediately; no done after release.
  - A fresh start computes correctly (0x23456789).
- (MULTIBYTE_ADD_SUB_EN) op=1, a=0x00000100, b=0x00000001 -> sum=0x000000FF, cy_out=1.
- (MULTIBYTE_ADD_SUB_EN) op=1, a=0x00000001, b=0x00000002 -> sum=0xFFFFFFFF, cy_out=0.
